text_tx_sequencer: RTL

TEXT_TX_SEQUENCER -- requirements
Module: text_tx_sequencer

---
 rtl/text_seq_pkg.sv | 18 +
 rtl/text_tx_sequencer_slot_strobe_latch.sv | 45 ++++
 rtl/text_tx_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/text_seq_pkg.sv
// Shared definitions for the text transmit sequencer.
//   TEXT_SEQ_ADDR_W : default text RAM address width
//   TEXT_SEQ_DATA_W : default text word width (matches codec sample width)
//   seq_state_e     : sequencer FSM state type
package text_seq_pkg;

  localparam int TEXT_SEQ_ADDR_W = 8;
  localparam int TEXT_SEQ_DATA_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WAIT_SLOT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/text_tx_sequencer_slot_strobe_latch.sv
// Rising-edge detector with a single-entry pending-slot flag.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   level_in : codec sample strobe (level)
//   clear    : drop the pending flag; wins over a coincident edge
//   pending  : a transmit slot has arrived and not yet been consumed
module slot_strobe_latch (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  input  logic clear,
  output logic pending
);

  logic level_q;
  logic level_d;
  logic pending_q;
  logic pending_d;
  logic rise;

  always_comb begin
    level_d   = level_in;
    rise      = level_in & ~level_q;
    pending_d = pending_q;
    if (clear) begin
      pending_d = 1'b0;
    end else if (rise) begin
      // A second edge while already pending collapses into the same slot.
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/text_tx_sequencer.sv
// Text transmit sequencer: reads msg_len words from the text RAM and
// hands one word to the text subsystem per codec sample slot.
//   clk, reset            : system clock, synchronous active-high reset
//   start, msg_len        : message request and length (sampled in IDLE)
//   read_ready            : codec sample strobe; each rising edge is a slot
//   ram_rden, ram_addr    : text RAM read port (data on ram_q one cycle later)
//   ram_q                 : text RAM read data
//   tx_data, tx_valid     : transmitted word and its one-cycle strobe
//   busy, done            : not-idle flag and end-of-message pulse
//   word_count            : words sent since the last accepted start
//   checksum              : XOR of sent words (only with TEXT_SEQ_CHECKSUM_EN)
module text_tx_sequencer
  import text_seq_pkg::*;
#(
  parameter int ADDR_W = TEXT_SEQ_ADDR_W,
  parameter int DATA_W = TEXT_SEQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] msg_len,
  input  logic              read_ready,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
`ifdef TEXT_SEQ_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;
`ifdef TEXT_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
`endif

  logic slot_pending;
  logic slot_clear;

  slot_strobe_latch u_slot (
    .clk      (clk),
    .reset    (reset),
    .level_in (read_ready),
    .clear    (slot_clear),
    .pending  (slot_pending)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wc_d       = wc_q;
    buf_d      = buf_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    slot_clear = 1'b0;
`ifdef TEXT_SEQ_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Slots are only collected while a message is in progress.
        slot_clear = 1'b1;
        if (start) begin
          len_d = msg_len;
          idx_d = '0;
          wc_d  = '0;
`ifdef TEXT_SEQ_CHECKSUM_EN
          chk_d = '0;
`endif
          state_d = (msg_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        buf_d   = ram_q;
        state_d = ST_WAIT_SLOT;
      end
      ST_WAIT_SLOT: begin
        if (slot_pending) begin
          tx_data_d  = buf_q;
          tx_valid_d = 1'b1;
          idx_d      = idx_q + ADDR_ONE;
          wc_d       = wc_q + ADDR_ONE;
          slot_clear = 1'b1;
`ifdef TEXT_SEQ_CHECKSUM_EN
          chk_d      = chk_q ^ buf_q;
`endif
          state_d    = ((wc_q + ADDR_ONE) == len_q) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        // done is registered, so it appears the cycle after the last tx_valid.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      wc_q       <= '0;
      buf_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef TEXT_SEQ_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wc_q       <= wc_d;
      buf_q      <= buf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
`ifdef TEXT_SEQ_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign ram_rden   = (state_q == ST_FETCH);
  assign ram_addr   = idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign done       = done_q;
  assign word_count = wc_q;
`ifdef TEXT_SEQ_CHECKSUM_EN
  assign checksum   = chk_q;
`endif

endmodule
